fir_out_requant_dec: RTL and testbench

Output-side consumer for the symmetric FIR filters. It takes the full-precision, valid-strobed filter output and drops all but one of every DECIM samples. It rounds and saturates the kept samples to the system word size and buffers them in a small FIFO behind a valid/ready interface for downstream blocks. The FIR stage cannot be stalled, so backpressure is absorbed by the FIFO, and any overflow is dropped and flagged.

---
 rtl/fir_out_requant_dec.sv | 183 ++++++++++++++++++
 tb/tb_fir_out_requant_dec.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_requant_dec.sv
// fir_out_requant_dec
// Output-side consumer for the symmetric FIR filters: keeps one of every
// DECIM valid samples, rounds (half-up) and saturates it to OUT_WORD_SIZE,
// and buffers the result in a small FIFO behind a valid/ready interface.
// The FIR side cannot be stalled, so a sample arriving at a full FIFO with
// no read that cycle is dropped and flagged.
module fir_out_requant_dec #(
    parameter int IN_WORD_SIZE  = 25,
    parameter int OUT_WORD_SIZE = 16,
    parameter int FRAC_SHIFT    = 5,
    parameter int DECIM         = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            clear_i,
    input  logic signed [IN_WORD_SIZE-1:0]  data_in,
    input  logic                            valid_in,
    output logic signed [OUT_WORD_SIZE-1:0] data_out,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic                            overflow_o,
    output logic                            drop_o
);

    localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int SUM_W   = IN_WORD_SIZE + 1;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FIFO_DEPTH);

    // Saturation bounds expressed at the full rounded width.
    localparam logic signed [SUM_W-1:0] C_MAX =
        {{(SUM_W - OUT_WORD_SIZE + 1){1'b0}}, {(OUT_WORD_SIZE - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] C_MIN =
        {{(SUM_W - OUT_WORD_SIZE + 1){1'b1}}, {(OUT_WORD_SIZE - 1){1'b0}}};

    logic [PHASE_W-1:0]             r_phase;
    logic signed [OUT_WORD_SIZE-1:0] r_stage_data;
    logic                           r_stage_valid;
    logic signed [OUT_WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]               r_wr_ptr;
    logic [PTR_W-1:0]               r_rd_ptr;
    logic [CNT_W-1:0]               r_count;
    logic                           r_overflow;
    logic                           r_drop;

    logic                           w_keep;
    logic signed [SUM_W-1:0]        w_half;
    logic signed [SUM_W-1:0]        w_sum;
    logic signed [SUM_W-1:0]        w_shift;
    logic                           w_sat_hi;
    logic                           w_sat_lo;
    logic signed [OUT_WORD_SIZE-1:0] w_req;
    logic                           w_full;
    logic                           w_rd;
    logic                           w_wr;
    logic                           w_drop;

    // A clear discards the same-cycle sample, so it must not be kept.
    assign w_keep = valid_in && (r_phase == '0) && !clear_i;

    // Phase counter: advances on every valid sample, wraps at DECIM-1.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_phase <= '0;
        end else if (clear_i) begin
            r_phase <= '0;
        end else if (valid_in) begin
            r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + 1'b1;
        end
    end

    // Round-half-up constant; absent when no fractional bits are dropped.
    generate
        if (FRAC_SHIFT > 0) begin : g_round
            assign w_half = SUM_W'(1) << (FRAC_SHIFT - 1);
        end else begin : g_no_round
            assign w_half = '0;
        end
    endgenerate

    // One extra bit of headroom keeps the rounding add from wrapping.
    assign w_sum    = {data_in[IN_WORD_SIZE-1], data_in} + w_half;
    assign w_shift  = w_sum >>> FRAC_SHIFT;
    assign w_sat_hi = (w_shift > C_MAX);
    assign w_sat_lo = (w_shift < C_MIN);

    // Clamp the rounded value into the output word.
    always_comb begin
        w_req = w_shift[OUT_WORD_SIZE-1:0];
        if (w_sat_hi) begin
            w_req = C_MAX[OUT_WORD_SIZE-1:0];
        end else if (w_sat_lo) begin
            w_req = C_MIN[OUT_WORD_SIZE-1:0];
        end
    end

    // Requantise stage register with its valid bit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stage_data  <= '0;
            r_stage_valid <= 1'b0;
        end else begin
            r_stage_valid <= w_keep;
            if (w_keep) begin
                r_stage_data <= w_req;
            end
        end
    end

    // FIFO control: a read frees a slot for a same-cycle write when full.
    assign valid_out = (r_count != '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_rd      = valid_out && ready_in && !clear_i;
    assign w_wr      = r_stage_valid && !clear_i && (!w_full || w_rd);
    assign w_drop    = r_stage_valid && !clear_i && w_full && !w_rd;

    // Storage entries; reset so the head reads zero out of reset.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
            // Write this entry when the write pointer selects it.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    r_mem[gi] <= '0;
                end else if (w_wr && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mem[gi] <= r_stage_data;
                end
            end
        end
    endgenerate

    assign data_out = r_mem[r_rd_ptr];

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky flags; clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_overflow <= 1'b0;
            r_drop     <= 1'b0;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            if (w_keep && (w_sat_hi || w_sat_lo)) begin
                r_overflow <= 1'b1;
            end
            if (w_drop) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign overflow_o = r_overflow;
    assign drop_o     = r_drop;

endmodule

// File: tb/tb_fir_out_requant_dec.sv
// Bench for fir_out_requant_dec: a DECIM=1 instance checked every cycle
// against a queue-based model plus literal expectations, and a DECIM=2
// instance checked with literal output sequences.
module tb_fir_out_requant_dec;

    localparam int IW = 25;
    localparam int OW = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic arst_n = 1'b0;

    logic                 clear_i = 1'b0;
    logic                 valid_in = 1'b0;
    logic                 ready_in = 1'b0;
    logic signed [IW-1:0] data_in = '0;
    logic signed [OW-1:0] data_out;
    logic                 valid_out;
    logic                 overflow_o;
    logic                 drop_o;

    logic                 d2_clear = 1'b0;
    logic                 d2_valid = 1'b0;
    logic                 d2_ready = 1'b1;
    logic signed [IW-1:0] d2_data = '0;
    logic signed [OW-1:0] d2_out;
    logic                 d2_vout;
    logic                 d2_ovf;
    logic                 d2_drop;

    int total = 0;
    int bad = 0;

    longint m_fifo[$];
    longint m_std = 0;
    bit     m_stv = 0;
    bit     m_ovf = 0;
    bit     m_drop = 0;

    longint rx[$];
    longint rx2[$];
    longint exp_q[$];

    fir_out_requant_dec #(
        .IN_WORD_SIZE(IW), .OUT_WORD_SIZE(OW), .FRAC_SHIFT(5),
        .DECIM(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arst_n(arst_n), .clear_i(clear_i),
        .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
        .overflow_o(overflow_o), .drop_o(drop_o)
    );

    fir_out_requant_dec #(
        .IN_WORD_SIZE(IW), .OUT_WORD_SIZE(OW), .FRAC_SHIFT(5),
        .DECIM(2), .FIFO_DEPTH(DEPTH)
    ) dut_d2 (
        .clk(clk), .arst_n(arst_n), .clear_i(d2_clear),
        .data_in(d2_data), .valid_in(d2_valid),
        .data_out(d2_out), .valid_out(d2_vout), .ready_in(d2_ready),
        .overflow_o(d2_ovf), .drop_o(d2_drop)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: floor((x + 16) / 32), clipped to 16-bit signed.
    function automatic longint rq_raw(longint x);
        return (x + 16) >>> 5;
    endfunction

    function automatic longint rq(longint x);
        longint t;
        t = rq_raw(x);
        if (t > 32767) return 32767;
        if (t < -32768) return -32768;
        return t;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string name, input longint got[$], input longint exp[$]);
        chk({name, "_len"}, longint'(got.size()), longint'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s_%0d", name, i), got[i], exp[i]);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_stv = 0;
        m_std = 0;
        m_ovf = 0;
        m_drop = 0;
    endtask

    // Behaviour of the DECIM=1 block across one clock edge.
    task automatic model_update();
        if (!arst_n) begin
            model_reset();
        end else if (clear_i) begin
            model_reset();
        end else begin
            if (m_fifo.size() != 0 && ready_in) void'(m_fifo.pop_front());
            if (m_stv) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_std);
                else m_drop = 1;
            end
            m_stv = valid_in;
            if (valid_in) begin
                m_std = rq(longint'(data_in));
                if (m_std != rq_raw(longint'(data_in))) m_ovf = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        d2_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input longint v);
        valid_in = 1'b1;
        data_in = IW'(v);
        step();
        valid_in = 1'b0;
    endtask

    task automatic d2_send(input longint v);
        d2_valid = 1'b1;
        d2_data = IW'(v);
        step();
        d2_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (arst_n) begin
                chk("m_valid", longint'(valid_out), longint'(m_fifo.size() != 0));
                if (m_fifo.size() != 0) chk("m_data", longint'(data_out), m_fifo[0]);
                chk("m_ovf", longint'(overflow_o), longint'(m_ovf));
                chk("m_drop", longint'(drop_o), longint'(m_drop));
            end
        end
    end

    // Record accepted transfers from both instances.
    initial begin
        forever begin
            @(negedge clk);
            if (arst_n && valid_out && ready_in && !clear_i) rx.push_back(longint'(data_out));
            if (arst_n && d2_vout && d2_ready && !d2_clear) rx2.push_back(longint'(d2_out));
        end
    end

    initial begin
        #3;
        chk("rst_data", longint'(data_out), 0);
        chk("rst_valid", longint'(valid_out), 0);
        chk("rst_ovf", longint'(overflow_o), 0);
        chk("rst_drop", longint'(drop_o), 0);
        chk("rst_d2_valid", longint'(d2_vout), 0);
        chk("rst_d2_data", longint'(d2_out), 0);
        #9;
        arst_n = 1'b1;
        step();

        // Rounding, with two-cycle latency
        ready_in = 1'b1;
        rx.delete();
        send(48);
        chk("lat_t1_valid", longint'(valid_out), 0);
        send(47);
        chk("lat_t2_valid", longint'(valid_out), 1);
        chk("lat_t2_data", longint'(data_out), 2);
        send(-48);
        send(-49);
        send(0);
        idle(4);
        exp_q = '{2, 1, -1, -2, 0};
        chk_q("round", rx, exp_q);
        chk("round_ovf", longint'(overflow_o), 0);

        // Saturation
        rx.delete();
        send(1048576);
        chk("sat_ovf_next", longint'(overflow_o), 1);
        send(-16777216);
        idle(4);
        exp_q = '{32767, -32768};
        chk_q("sat", rx, exp_q);
        do_clear();
        chk("sat_clr_ovf", longint'(overflow_o), 0);

        // Backpressure with overflow of the FIFO
        ready_in = 1'b0;
        rx.delete();
        for (int k = 1; k <= 6; k++) send(32 * k);
        idle(2);
        chk("bp_valid", longint'(valid_out), 1);
        chk("bp_drop", longint'(drop_o), 1);
        ready_in = 1'b1;
        idle(6);
        exp_q = '{1, 2, 3, 4};
        chk_q("bp", rx, exp_q);
        chk("bp_empty", longint'(valid_out), 0);
        do_clear();

        // Full FIFO with simultaneous read and write
        ready_in = 1'b0;
        rx.delete();
        for (int k = 1; k <= 5; k++) send(32 * k);
        ready_in = 1'b1;
        idle(1);
        ready_in = 1'b0;
        idle(1);
        chk("rw_drop", longint'(drop_o), 0);
        ready_in = 1'b1;
        idle(6);
        exp_q = '{1, 2, 3, 4, 5};
        chk_q("rw", rx, exp_q);

        // Clear mid-stream with a same-cycle valid sample
        ready_in = 1'b0;
        send(1048576);
        send(64);
        send(96);
        idle(1);
        chk("clr_pre_ovf", longint'(overflow_o), 1);
        chk("clr_pre_valid", longint'(valid_out), 1);
        clear_i = 1'b1;
        valid_in = 1'b1;
        data_in = IW'(320);
        ready_in = 1'b1;
        step();
        clear_i = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        chk("clr_valid", longint'(valid_out), 0);
        chk("clr_ovf", longint'(overflow_o), 0);
        chk("clr_drop", longint'(drop_o), 0);
        send(64);
        idle(1);
        chk("clr_next_valid", longint'(valid_out), 1);
        chk("clr_next_data", longint'(data_out), 2);
        ready_in = 1'b1;
        idle(3);

        // Asynchronous reset mid-stream
        ready_in = 1'b0;
        send(1048576);
        send(64);
        send(96);
        idle(1);
        chk("ar_pre_ovf", longint'(overflow_o), 1);
        valid_in = 1'b1;
        data_in = IW'(320);
        arst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_data", longint'(data_out), 0);
        chk("ar_valid", longint'(valid_out), 0);
        chk("ar_ovf", longint'(overflow_o), 0);
        chk("ar_drop", longint'(drop_o), 0);
        #1;
        arst_n = 1'b1;
        step();
        valid_in = 1'b0;
        idle(1);
        chk("ar_next_valid", longint'(valid_out), 1);
        chk("ar_next_data", longint'(data_out), 10);
        ready_in = 1'b1;
        idle(3);

        // Decimation by 2: back-to-back then with gaps
        rx2.delete();
        d2_send(32);
        d2_send(64);
        d2_send(96);
        d2_send(128);
        idle(4);
        exp_q = '{1, 3};
        chk_q("dec_b2b", rx2, exp_q);
        rx2.delete();
        d2_send(32);
        idle(2);
        d2_send(64);
        idle(3);
        d2_send(96);
        idle(1);
        d2_send(128);
        idle(4);
        chk_q("dec_gap", rx2, exp_q);

        // Clear returns the phase to 0 and discards the same-cycle sample
        d2_send(32);
        idle(3);
        rx2.delete();
        d2_clear = 1'b1;
        d2_valid = 1'b1;
        d2_data = IW'(31968);
        step();
        d2_clear = 1'b0;
        d2_valid = 1'b0;
        d2_send(64);
        idle(3);
        exp_q = '{2};
        chk_q("dec_clr", rx2, exp_q);
        chk("dec_ovf", longint'(d2_ovf), 0);
        chk("dec_drop", longint'(d2_drop), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
